hall_pulse_gen: RTL and testbench
=================================

# hall_pulse_gen

Hall-sensor emulator for the bicycle speed/distance path: the transmitting end of the hall-pulse interface that the speed and distance counters consume. It converts a commanded wheel-rotation period into a square hall waveform and generates the periodic one-cycle measurement gate used to clear the speed counter. It also keeps reference counts: total edges and edges per gate window. Benches and bring-up boards use it to drive the counters with known, reproducible rates.

## Interface
- PERIOD_W, 16: width of the period configuration, in clk cycles.
- GATE_CYCLES, 100: gate window length, in clk cycles.
- SPEED_W, 9: width of `window_count`. Matches the speed result width.
- DIST_W, 13: width of `pulse_count`. Matches the distance result width.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  pulse generation allowed.
- cfg_valid  in  1  new period offered.
- cfg_ready  out  1  pending slot free.
- cfg_period  in  PERIOD_W  clk cycles between hall rising edges.
- hall  out  1  emulated hall-sensor output. Registered.
- gate  out  1  one-cycle pulse every GATE_CYCLES cycles.
- window_count  out  SPEED_W  rising edges counted in the last completed gate window.
- pulse_count  out  DIST_W  rising edges since reset. Wraps.

## Operation
- Registers:
  - `active_period`: the period currently being generated.
  - `pending`: a 1-entry buffer for a new period, plus a pending-valid flag.
- Config handshake:
  - A transfer occurs on a cycle where cfg_valid=1 and cfg_ready=1.
  - cfg_ready = !pending_valid.
  - In IDLE, a pending value moves to `active_period` on the next cycle.
  - Otherwise the pending value is applied only at the LOW→HIGH boundary. A period in progress is never truncated.
- Phase lengths: high phase H = active_period>>1 cycles; low phase L = active_period − H cycles.
- Period values 0 and 1 mean "stopped". When applied, the FSM goes to IDLE.
- FSM states:
  - IDLE: hall=0. Go to HIGH when enable=1 and active_period≥2.
  - HIGH: hall=1 for H cycles, then go to LOW.
  - LOW: hall=0 for L cycles. At the end, apply pending if present. Then go to HIGH, or to IDLE if the new period is stopped.
- enable=0 in any state forces IDLE on the next cycle with hall=0. The phase counter clears; active and pending registers are kept.
- Edge counting: every IDLE/LOW→HIGH transition is one edge.
  - pulse_count increments in the same cycle hall first reads 1.
  - Wrap is modulo 2^DIST_W: 8191→0 at the default width.
- Gate timer:
  - Free-running from reset deassertion, independent of enable.
  - gate=1 on cycles GATE_CYCLES−1, 2·GATE_CYCLES−1, … counted from reset release.
- Window counting:
  - On a gate cycle, window_count ← edges counted in the window. An internal window counter, separate from pulse_count, counts those edges.
  - The window counter then restarts at 0, or at 1 if an edge coincides with the gate cycle. A coincident edge belongs to the new window.
  - The window counter saturates at 2^SPEED_W−1.

## Timing
- Reset values: hall=0, gate=0, window_count=0, pulse_count=0, cfg_ready=1, FSM=IDLE, active_period=0, gate timer=0.
- Reset is asynchronous. Asserting it mid-HIGH drops hall immediately and discards any pending config.
- Startup latency:
  - A cfg transfer in IDLE with enable=1 at cycle t: active_period is loaded at t+1 and hall=1 at t+2.
  - When enable rises in IDLE with a valid period, hall=1 on the second cycle after the rise.
- Steady state: hall is periodic with exactly active_period cycles between rising edges, with no boundary bubbles.
- Config applied at a boundary: the first HIGH of the new period begins on the cycle directly after the last LOW cycle of the old one.
- cfg_ready returns to 1 on the cycle after the pending value is consumed.

## Structure
- Shared package `bike_pkg`:
  - SPEED_W=9, DIST_W=13.
  - FSM state enum {IDLE, HIGH, LOW}.
  - Shared with the speed and distance blocks.
- Sub-module `gate_timer`: the free-running modulo-GATE_CYCLES counter producing `gate`. The FSM, config buffer and edge counters stay in the top module.

## Test plan
- Period 10, GATE_CYCLES=100, enable=1 → hall is 5 high / 5 low; window_count=10 after every gate from the second gate on.
- Period 7 → hall is 3 high / 4 low; window_count alternates between 14 and 15. The sum over 7 windows is 100.
- Period 10 running, cfg 20 offered mid-HIGH → the current period completes at 10 cycles. The next rising edge comes 10 cycles after the previous one, and subsequent edges 20 apart.
- Two cfg offers back-to-back mid-period → first accepted, cfg_ready=0 until the boundary, second accepted the cycle after cfg_ready returns to 1.
- Period 2 run until pulse_count reaches 8191 → the next edge gives 0. window_count saturates at 50 and never reaches 511.
- Reset asserted mid-HIGH, and enable dropped mid-LOW → hall=0 immediately or on the next cycle respectively. All outputs reach their reset values on reset, and counts are unchanged on enable drop.

Source files
------------

// File: rtl/bike_pkg.sv
// Shared definitions for the bicycle speed/distance path: result widths and
// the hall emulator's FSM states.
package bike_pkg;

    localparam int SPEED_W = 9;
    localparam int DIST_W  = 13;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } hall_state_t;

endpackage

// File: rtl/gate_timer.sv
// Free-running modulo-GATE_CYCLES counter; gate is high on the last count of
// every window, counted from reset release.
module gate_timer #(
    parameter int GATE_CYCLES = 100
) (
    input  logic clk,
    input  logic reset,
    output logic gate
);

    localparam int CNT_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(GATE_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            count <= (count == LAST) ? '0 : count + CNT_W'(1);
        end
    end

    assign gate = (count == LAST);

endmodule

// File: rtl/hall_pulse_gen.sv
// Hall-sensor emulator: turns a commanded rotation period into a square hall
// waveform, with a gate pulse and reference edge counts for the speed/distance path.
module hall_pulse_gen #(
    parameter int PERIOD_W    = 16,
    parameter int GATE_CYCLES = 100,
    parameter int SPEED_W     = bike_pkg::SPEED_W,
    parameter int DIST_W      = bike_pkg::DIST_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [PERIOD_W-1:0] cfg_period,
    output logic                hall,
    output logic                gate,
    output logic [SPEED_W-1:0]  window_count,
    output logic [DIST_W-1:0]   pulse_count
);

    import bike_pkg::*;

    hall_state_t         state;
    logic [PERIOD_W-1:0] active_period;
    logic [PERIOD_W-1:0] pending_period;
    logic                pending_valid;
    logic [PERIOD_W-1:0] phase;
    logic                enable_q;
    logic [SPEED_W-1:0]  win_cnt;

    logic [PERIOD_W-1:0] high_len;
    logic [PERIOD_W-1:0] low_len;
    logic [PERIOD_W-1:0] next_period;
    logic                transfer;
    logic                boundary;
    logic                start_idle;
    logic                start_low;
    logic                edge_now;
    logic                idle_load;
    logic                apply;

    gate_timer #(
        .GATE_CYCLES (GATE_CYCLES)
    ) u_gate_timer (
        .clk   (clk),
        .reset (reset),
        .gate  (gate)
    );

    assign cfg_ready   = !pending_valid;
    assign transfer    = cfg_valid && cfg_ready;
    assign high_len    = active_period >> 1;
    assign low_len     = active_period - high_len;
    assign boundary    = (state == LOW) && (phase == low_len - PERIOD_W'(1));
    assign next_period = pending_valid ? pending_period : active_period;

    // A start from IDLE waits one cycle after enable rises and after any pending load.
    assign start_idle = (state == IDLE) && enable && enable_q && !pending_valid
                        && (active_period >= PERIOD_W'(2));
    assign start_low  = boundary && enable && (next_period >= PERIOD_W'(2));
    assign edge_now   = start_idle || start_low;
    assign idle_load  = (state == IDLE) && !start_idle;
    assign apply      = idle_load || (boundary && enable);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            hall           <= 1'b0;
            phase          <= '0;
            active_period  <= '0;
            pending_period <= '0;
            pending_valid  <= 1'b0;
            enable_q       <= 1'b0;
        end else begin
            enable_q <= enable;

            // In IDLE a fresh offer bypasses the buffer; while running it waits for the boundary.
            if (apply && pending_valid) begin
                active_period <= pending_period;
                pending_valid <= 1'b0;
            end else if (idle_load && transfer) begin
                active_period <= cfg_period;
            end else if (transfer) begin
                pending_period <= cfg_period;
                pending_valid  <= 1'b1;
            end

            if (!enable) begin
                state <= IDLE;
                hall  <= 1'b0;
                phase <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_idle) begin
                            state <= HIGH;
                            hall  <= 1'b1;
                            phase <= '0;
                        end
                    end
                    HIGH: begin
                        if (phase == high_len - PERIOD_W'(1)) begin
                            state <= LOW;
                            hall  <= 1'b0;
                            phase <= '0;
                        end else begin
                            phase <= phase + PERIOD_W'(1);
                        end
                    end
                    LOW: begin
                        if (boundary) begin
                            state <= start_low ? HIGH : IDLE;
                            hall  <= start_low;
                            phase <= '0;
                        end else begin
                            phase <= phase + PERIOD_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        hall  <= 1'b0;
                        phase <= '0;
                    end
                endcase
            end
        end
    end

    // An edge landing on the gate cycle opens the new window rather than closing the old one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pulse_count  <= '0;
            window_count <= '0;
            win_cnt      <= '0;
        end else begin
            if (edge_now) begin
                pulse_count <= pulse_count + DIST_W'(1);
            end
            if (gate) begin
                window_count <= win_cnt;
                win_cnt      <= edge_now ? SPEED_W'(1) : '0;
            end else if (edge_now && (win_cnt != '1)) begin
                win_cnt <= win_cnt + SPEED_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hall_pulse_gen.sv
// Directed bench for hall_pulse_gen: waveform shape, config handshake,
// gate/window counts, wrap, enable and reset behaviour.
module tb_hall_pulse_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_period;
    logic        hall;
    logic        gate;
    logic [8:0]  window_count;
    logic [12:0] pulse_count;

    int total  = 0;
    int passed = 0;

    hall_pulse_gen dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_period   (cfg_period),
        .hall         (hall),
        .gate         (gate),
        .window_count (window_count),
        .pulse_count  (pulse_count)
    );

    always #5 clk = ~clk;

    initial begin
        #10000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [15:0] period, input logic en);
        cfg_valid  = valid;
        cfg_period = period;
        enable     = en;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    // Length of the current hall level, leaving us on the first cycle of the other level.
    task automatic phaseLen(output int len);
        logic lvl;
        lvl = hall;
        len = 0;
        while (hall == lvl && len < 1000) begin
            len++;
            tick();
        end
    endtask

    task automatic countToRise(input string tag, output int n);
        logic prev;
        logic found;
        prev  = hall;
        found = 1'b0;
        n     = 0;
        while (!found && n < 200) begin
            tick();
            n++;
            found = hall && !prev;
            prev  = hall;
        end
        checkOutput(tag, found, 1);
    endtask

    // Advances to the cycle after a gate, when window_count has just been updated.
    task automatic waitGate(input string tag);
        int n;
        n = 0;
        tick();
        while (gate !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        checkOutput(tag, gate, 1);
        tick();
    endtask

    initial begin
        int n;
        int len;
        int sum;
        int p;
        logic any_high;

        reset = 1'b0;
        applyStimulus(0, 16'd0, 0);
        tick();
        tick();
        tick();
        checkOutput("rst_hall", hall, 0);
        checkOutput("rst_gate", gate, 0);
        checkOutput("rst_window", window_count, 0);
        checkOutput("rst_pulse", pulse_count, 0);
        checkOutput("rst_ready", cfg_ready, 1);

        $display("[TB] period 10 startup and shape");
        reset = 1'b1;
        applyStimulus(1, 16'd10, 1);
        tick();
        applyStimulus(0, 16'd10, 1);
        checkOutput("lat_t1_hall", hall, 0);
        checkOutput("lat_t1_ready", cfg_ready, 1);
        tick();
        checkOutput("lat_t2_hall", hall, 1);
        checkOutput("lat_t2_pulse", pulse_count, 1);
        phaseLen(len);
        checkOutput("p10_high", len, 5);
        phaseLen(len);
        checkOutput("p10_low", len, 5);
        waitGate("p10_gate1");
        waitGate("p10_gate2");
        checkOutput("p10_win2", window_count, 10);
        waitGate("p10_gate3");
        checkOutput("p10_win3", window_count, 10);

        $display("[TB] period 7 windows");
        applyStimulus(1, 16'd7, 1);
        tick();
        applyStimulus(0, 16'd7, 1);
        waitGate("p7_skip1");
        waitGate("p7_skip2");
        sum = 0;
        for (int i = 0; i < 7; i++) begin
            waitGate("p7_gate");
            checkOutput("p7_win_14_or_15", (window_count == 9'd14) || (window_count == 9'd15), 1);
            sum += int'(window_count);
        end
        checkOutput("p7_sum", sum, 100);
        countToRise("p7_sync", n);
        phaseLen(len);
        checkOutput("p7_high", len, 3);
        phaseLen(len);
        checkOutput("p7_low", len, 4);

        $display("[TB] reconfiguration at the boundary and back-to-back offers");
        applyStimulus(1, 16'd10, 1);
        tick();
        applyStimulus(0, 16'd10, 1);
        countToRise("p10b_sync", n);
        countToRise("p10b_rise", n);
        checkOutput("p10b_interval", n, 10);
        tick();
        tick();
        applyStimulus(1, 16'd20, 1);
        tick();
        checkOutput("busy_after_first", cfg_ready, 0);
        applyStimulus(1, 16'd30, 1);
        countToRise("cut_rise", n);
        checkOutput("no_truncate", n + 3, 10);
        checkOutput("ready_back", cfg_ready, 1);
        tick();
        checkOutput("second_accepted", cfg_ready, 0);
        applyStimulus(0, 16'd30, 1);
        countToRise("p20_rise", n);
        checkOutput("p20_interval", n + 1, 20);
        countToRise("p30_rise", n);
        checkOutput("p30_interval", n, 30);

        $display("[TB] period 2 windows and distance wrap");
        checkOutput("ready_before_p2", cfg_ready, 1);
        applyStimulus(1, 16'd2, 1);
        tick();
        applyStimulus(0, 16'd2, 1);
        waitGate("p2_skip1");
        waitGate("p2_skip2");
        waitGate("p2_gate3");
        checkOutput("p2_win3", window_count, 50);
        waitGate("p2_gate4");
        checkOutput("p2_win4", window_count, 50);
        n = 0;
        while (pulse_count != 13'd8191 && n < 20000) begin
            tick();
            n++;
        end
        checkOutput("reach_8191", pulse_count, 8191);
        n = 0;
        while (pulse_count == 13'd8191 && n < 4) begin
            tick();
            n++;
        end
        checkOutput("wrap_to_0", pulse_count, 0);

        $display("[TB] enable drop and restart");
        applyStimulus(1, 16'd10, 1);
        tick();
        applyStimulus(0, 16'd10, 1);
        countToRise("en_sync1", n);
        countToRise("en_sync2", n);
        for (int i = 0; i < 6; i++) tick();
        p = int'(pulse_count);
        applyStimulus(0, 16'd10, 0);
        tick();
        checkOutput("drop_low_hall", hall, 0);
        any_high = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            any_high |= hall;
        end
        checkOutput("disabled_quiet", any_high, 0);
        checkOutput("disabled_count", pulse_count, 13'(p));
        applyStimulus(0, 16'd10, 1);
        tick();
        tick();
        checkOutput("enable_rise_hall", hall, 1);
        checkOutput("enable_rise_count", pulse_count, 13'(p + 1));
        applyStimulus(0, 16'd10, 0);
        tick();
        checkOutput("drop_high_hall", hall, 0);
        applyStimulus(0, 16'd10, 1);
        tick();
        tick();
        checkOutput("restart_hall", hall, 1);

        $display("[TB] reset mid-HIGH");
        applyStimulus(1, 16'd40, 1);
        tick();
        applyStimulus(0, 16'd40, 1);
        checkOutput("pending_held", cfg_ready, 0);
        checkOutput("still_high", hall, 1);
        reset = 1'b0;
        #1;
        checkOutput("async_hall", hall, 0);
        checkOutput("async_pulse", pulse_count, 0);
        checkOutput("async_window", window_count, 0);
        checkOutput("async_gate", gate, 0);
        checkOutput("async_ready", cfg_ready, 1);
        tick();
        reset = 1'b1;
        any_high = 1'b0;
        n = 0;
        while (gate !== 1'b1 && n < 300) begin
            tick();
            n++;
            any_high |= hall;
        end
        checkOutput("gate_after_release", n, 99);
        checkOutput("pending_discarded", any_high, 0);
        checkOutput("post_reset_pulse", pulse_count, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
